// File: rtl/idex_hazard_stage.sv
// ID/EX pipeline register with a one-bubble load-use interlock, honouring the
// global mem_stall freeze and branch flush; counts inserted bubbles (saturating).
module idex_hazard_stage #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [OP_W-1:0]   id_opcode,
   input  logic [REG_W-1:0]  id_src1,
   input  logic [REG_W-1:0]  id_src2,
   input  logic [REG_W-1:0]  id_dest,
   input  logic              id_ld_dest,
   input  logic              id_bit5,
   input  logic              id_bit11,
   input  logic [DATA_W-1:0] id_sr1,
   input  logic [DATA_W-1:0] id_sr2,
   input  logic [DATA_W-1:0] id_pc,
   input  logic              mem_stall,
   input  logic              flush,
   output logic              idex_valid,
   output logic [OP_W-1:0]   idex_opcode,
   output logic [REG_W-1:0]  idex_src1,
   output logic [REG_W-1:0]  idex_src2,
   output logic [REG_W-1:0]  idex_dest,
   output logic              idex_ld_dest,
   output logic              idex_bit5,
   output logic              idex_bit11,
   output logic [DATA_W-1:0] idex_sr1,
   output logic [DATA_W-1:0] idex_sr2,
   output logic [DATA_W-1:0] idex_pc,
   output logic              ifid_hold,
   output logic              bubble,
   output logic [CNT_W-1:0]  stall_count,
   output logic              state_dbg
);

   typedef enum logic {S_RUN = 1'b0, S_BUBBLE = 1'b1} state_t;

   typedef struct packed {
      logic              valid;
      logic [OP_W-1:0]   opcode;
      logic [REG_W-1:0]  src1;
      logic [REG_W-1:0]  src2;
      logic [REG_W-1:0]  dest;
      logic              ld_dest;
      logic              bit5;
      logic              bit11;
      logic [DATA_W-1:0] sr1;
      logic [DATA_W-1:0] sr2;
      logic [DATA_W-1:0] pc;
   } stage_t;

   localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LDB = OP_W'(2);
   localparam logic [OP_W-1:0] OP_STB = OP_W'(3);
   localparam logic [OP_W-1:0] OP_JSR = OP_W'(4);
   localparam logic [OP_W-1:0] OP_AND = OP_W'(5);
   localparam logic [OP_W-1:0] OP_LDR = OP_W'(6);
   localparam logic [OP_W-1:0] OP_STR = OP_W'(7);
   localparam logic [OP_W-1:0] OP_NOT = OP_W'(9);
   localparam logic [OP_W-1:0] OP_LDI = OP_W'(10);
   localparam logic [OP_W-1:0] OP_STI = OP_W'(11);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(12);
   localparam logic [OP_W-1:0] OP_SHF = OP_W'(13);

   state_t           state_q, state_d;
   stage_t           stage_q, stage_d;
   logic             bubble_q, bubble_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             uses1, uses2, ex_is_load, hazard, hold_c;

   always_comb begin
      uses1 = 1'b0;
      uses2 = 1'b0;
      case (id_opcode)
         OP_ADD, OP_AND: begin
            uses1 = 1'b1;
            uses2 = ~id_bit5;
         end
         OP_STB, OP_STI, OP_STR: begin
            uses1 = 1'b1;
            uses2 = 1'b1;
         end
         OP_JMP, OP_LDB, OP_LDI, OP_LDR, OP_NOT, OP_SHF: uses1 = 1'b1;
         OP_JSR: uses1 = ~id_bit11;
         default: ;
      endcase
   end

   assign ex_is_load = stage_q.valid & stage_q.ld_dest &
                       ((stage_q.opcode == OP_LDB) | (stage_q.opcode == OP_LDI) |
                        (stage_q.opcode == OP_LDR));
   assign hazard = ex_is_load & id_valid &
                   ((uses1 & (id_src1 == stage_q.dest)) | (uses2 & (id_src2 == stage_q.dest)));

   // Priority: mem_stall freezes everything, flush squashes, then interlock, then advance.
   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      bubble_d = bubble_q;
      cnt_d    = cnt_q;
      hold_c   = 1'b0;
      if (mem_stall) begin
         hold_c = 1'b1;
      end else if (flush) begin
         stage_d  = '0;
         bubble_d = 1'b0;
         state_d  = S_RUN;
      end else if ((state_q == S_RUN) && hazard) begin
         stage_d  = '0;
         bubble_d = 1'b1;
         state_d  = S_BUBBLE;
         hold_c   = 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end else begin
         stage_d.valid   = id_valid;
         stage_d.opcode  = id_opcode;
         stage_d.src1    = id_src1;
         stage_d.src2    = id_src2;
         stage_d.dest    = id_dest;
         stage_d.ld_dest = id_ld_dest;
         stage_d.bit5    = id_bit5;
         stage_d.bit11   = id_bit11;
         stage_d.sr1     = id_sr1;
         stage_d.sr2     = id_sr2;
         stage_d.pc      = id_pc;
         bubble_d        = 1'b0;
         state_d         = S_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_RUN;
         stage_q  <= '0;
         bubble_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         stage_q  <= stage_d;
         bubble_q <= bubble_d;
         cnt_q    <= cnt_d;
      end
   end

   // Hold is forced low while reset is asserted so every output reads zero.
   assign ifid_hold    = rst_n & hold_c;
   assign idex_valid   = stage_q.valid;
   assign idex_opcode  = stage_q.opcode;
   assign idex_src1    = stage_q.src1;
   assign idex_src2    = stage_q.src2;
   assign idex_dest    = stage_q.dest;
   assign idex_ld_dest = stage_q.ld_dest;
   assign idex_bit5    = stage_q.bit5;
   assign idex_bit11   = stage_q.bit11;
   assign idex_sr1     = stage_q.sr1;
   assign idex_sr2     = stage_q.sr2;
   assign idex_pc      = stage_q.pc;
   assign bubble       = bubble_q;
   assign stall_count  = cnt_q;
   assign state_dbg    = state_q;

endmodule
